// File: rtl/vga_sync_decoder_if.sv
// Sync-side bundle between a VGA display controller (master) and the timing decoder (slave).
// Carries the raw sync/bright inputs plus everything the decoder reports back.
interface vga_sync_decoder_if;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       pixEn;
    logic       frameStart;
    logic       locked;
    logic       syncErr;
    logic       brightErr;
    logic [7:0] errCount;

    modport master (
        output hSync, vSync, bright,
        input  hCount, vCount, pixEn, frameStart, locked, syncErr, brightErr, errCount
    );

    modport slave (
        input  hSync, vSync, bright,
        output hCount, vCount, pixEn, frameStart, locked, syncErr, brightErr, errCount
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel/line position from VGA sync falls, verifies line and frame lengths,
// and reports lock, sync errors and active-window (bright) mismatches.
module vga_sync_decoder #(
    parameter int CLKS_PER_PIX = 4,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACT_START  = 144,
    parameter int H_ACT_END    = 783,
    parameter int V_ACT_START  = 35,
    parameter int V_ACT_END    = 514,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    vga_sync_decoder_if.slave  bus
);
    localparam int LINE_CLKS = H_TOTAL * CLKS_PER_PIX;
    localparam int DW        = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
    localparam int GW        = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, LINE, TRACK, LOCKED} state_t;

    state_t        state, state_d;
    logic [GW-1:0] good_cnt, good_d;
    logic          hs_q, vs_q, bright_q;
    logic [DW-1:0] div;
    logic [12:0]   line_clks;
    logic          h_fall, v_fall, pix_tick, checking;
    logic          line_err, lost_err, frame_err, align_err, err;
    logic          bright_exp;

    assign h_fall   = hs_q & ~bus.hSync;
    assign v_fall   = vs_q & ~bus.vSync;
    assign pix_tick = (div == DW'(CLKS_PER_PIX - 1));
    assign checking = (state == TRACK) || (state == LOCKED);

    // lost_err fires exactly once, the first clock the line runs past nominal length
    assign line_err  = h_fall && (line_clks != 13'(LINE_CLKS));
    assign lost_err  = !h_fall && (line_clks == 13'(LINE_CLKS + 1));
    assign frame_err = h_fall && v_fall && (bus.vCount != 10'(V_TOTAL - 1));
    assign align_err = v_fall && !h_fall;
    assign err       = checking && (line_err || lost_err || frame_err || align_err);

    assign bright_exp = (bus.hCount >= 10'(H_ACT_START)) && (bus.hCount <= 10'(H_ACT_END)) &&
                        (bus.vCount >= 10'(V_ACT_START)) && (bus.vCount <= 10'(V_ACT_END));

    always_comb begin
        state_d = state;
        good_d  = good_cnt;
        case (state)
            SEARCH: if (h_fall) state_d = LINE;
            LINE: if (h_fall && v_fall) begin
                state_d = TRACK;
                good_d  = '0;
            end
            TRACK: if (h_fall && v_fall) begin
                good_d = good_cnt + 1'b1;
                if (good_d == GW'(LOCK_FRAMES)) state_d = LOCKED;
            end
            LOCKED: state_d = LOCKED;
            default: state_d = SEARCH;
        endcase
        if (err) begin
            state_d = SEARCH;
            good_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= SEARCH;
            good_cnt       <= '0;
            hs_q           <= 1'b0;
            vs_q           <= 1'b0;
            bright_q       <= 1'b0;
            div            <= '0;
            line_clks      <= '0;
            bus.hCount     <= '0;
            bus.vCount     <= '0;
            bus.pixEn      <= 1'b0;
            bus.frameStart <= 1'b0;
            bus.locked     <= 1'b0;
            bus.syncErr    <= 1'b0;
            bus.brightErr  <= 1'b0;
            bus.errCount   <= '0;
        end else begin
            state    <= state_d;
            good_cnt <= good_d;
            hs_q     <= bus.hSync;
            vs_q     <= bus.vSync;
            bright_q <= bus.bright;
            if (h_fall) begin
                div        <= '0;
                line_clks  <= 13'd1;
                bus.hCount <= '0;
                bus.pixEn  <= 1'b1;
                if (v_fall)
                    bus.vCount <= '0;
                else if (bus.vCount != 10'(V_TOTAL - 1))
                    bus.vCount <= bus.vCount + 1'b1;
            end else begin
                div       <= pix_tick ? '0 : div + 1'b1;
                bus.pixEn <= pix_tick;
                if (pix_tick && (bus.hCount != 10'(H_TOTAL - 1)))
                    bus.hCount <= bus.hCount + 1'b1;
                if (line_clks != '1)
                    line_clks <= line_clks + 1'b1;
            end
            bus.frameStart <= h_fall && v_fall;
            bus.syncErr    <= err;
            bus.locked     <= (state_d == LOCKED);
            if (err && (bus.errCount != 8'hFF))
                bus.errCount <= bus.errCount + 8'd1;
            // bright_q lines up with the pixel whose pixEn/hCount are showing now
            if ((state == LOCKED) && bus.pixEn && (bright_q != bright_exp))
                bus.brightErr <= 1'b1;
        end
    end
endmodule
